// File: rtl/nf10_rr_input_arbiter.sv
// nf10_rr_input_arbiter
//   Merges five AXI4-Stream packet inputs into one output stream.
//   Arbitration is round-robin with packet granularity: once an input is
//   granted, it keeps the output until its tlast beat has been accepted.
//   A 32-bit packet counter per input is exported for the register block.
//
// Ports
//   axi_aclk, axi_reset         : clock, synchronous active-high reset
//   s_axis_*_0 .. s_axis_*_4    : five AXI4-Stream slave inputs
//   m_axis_*                    : merged AXI4-Stream master output
//   rst_cntrs                   : synchronous clear of all packet counters
//   pkt_in_cntr_0 .. _4         : packets accepted from each input
//   grant_idx                   : currently granted input (meaningful in SEND)
module nf10_rr_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5
) (
  input  logic                                axi_aclk,
  input  logic                                axi_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_0,
  input  logic                                s_axis_tvalid_0,
  output logic                                s_axis_tready_0,
  input  logic                                s_axis_tlast_0,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_1,
  input  logic                                s_axis_tvalid_1,
  output logic                                s_axis_tready_1,
  input  logic                                s_axis_tlast_1,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_2,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_2,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_2,
  input  logic                                s_axis_tvalid_2,
  output logic                                s_axis_tready_2,
  input  logic                                s_axis_tlast_2,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_3,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_3,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_3,
  input  logic                                s_axis_tvalid_3,
  output logic                                s_axis_tready_3,
  input  logic                                s_axis_tlast_3,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_4,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_4,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_4,
  input  logic                                s_axis_tvalid_4,
  output logic                                s_axis_tready_4,
  input  logic                                s_axis_tlast_4,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,

  input  logic                                rst_cntrs,
  output logic [31:0]                         pkt_in_cntr_0,
  output logic [31:0]                         pkt_in_cntr_1,
  output logic [31:0]                         pkt_in_cntr_2,
  output logic [31:0]                         pkt_in_cntr_3,
  output logic [31:0]                         pkt_in_cntr_4,
  output logic [2:0]                          grant_idx
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  lastGrant_q, lastGrant_d;
  logic [2:0]  grant_q, grant_d;
  logic [31:0] pktCnt_q [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] validVec;
  logic [NUM_QUEUES-1:0] readyVec;
  logic                  selValid;
  logic                  selLast;
  logic                  endOfPkt;
  logic                  found;
  logic [2:0]            pick;
  logic [3:0]            probe;

  assign validVec = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2,
                     s_axis_tvalid_1, s_axis_tvalid_0};

  // Output mux follows the grant register at all times; in IDLE the data is
  // a don't-care because tvalid is forced low.
  always_comb begin
    m_axis_tdata = s_axis_tdata_0;
    m_axis_tstrb = s_axis_tstrb_0;
    m_axis_tuser = s_axis_tuser_0;
    selValid     = s_axis_tvalid_0;
    selLast      = s_axis_tlast_0;
    case (grant_q)
      3'd1: begin
        m_axis_tdata = s_axis_tdata_1;
        m_axis_tstrb = s_axis_tstrb_1;
        m_axis_tuser = s_axis_tuser_1;
        selValid     = s_axis_tvalid_1;
        selLast      = s_axis_tlast_1;
      end
      3'd2: begin
        m_axis_tdata = s_axis_tdata_2;
        m_axis_tstrb = s_axis_tstrb_2;
        m_axis_tuser = s_axis_tuser_2;
        selValid     = s_axis_tvalid_2;
        selLast      = s_axis_tlast_2;
      end
      3'd3: begin
        m_axis_tdata = s_axis_tdata_3;
        m_axis_tstrb = s_axis_tstrb_3;
        m_axis_tuser = s_axis_tuser_3;
        selValid     = s_axis_tvalid_3;
        selLast      = s_axis_tlast_3;
      end
      3'd4: begin
        m_axis_tdata = s_axis_tdata_4;
        m_axis_tstrb = s_axis_tstrb_4;
        m_axis_tuser = s_axis_tuser_4;
        selValid     = s_axis_tvalid_4;
        selLast      = s_axis_tlast_4;
      end
      default: ;
    endcase
  end

  assign m_axis_tvalid = (state_q == SEND) & selValid;
  assign m_axis_tlast  = selLast;
  assign endOfPkt      = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Only the granted input sees downstream ready, and only while sending.
  always_comb begin
    readyVec = '0;
    if (state_q == SEND) readyVec[grant_q] = m_axis_tready;
  end

  assign s_axis_tready_0 = readyVec[0];
  assign s_axis_tready_1 = readyVec[1];
  assign s_axis_tready_2 = readyVec[2];
  assign s_axis_tready_3 = readyVec[3];
  assign s_axis_tready_4 = readyVec[4];

  // Round-robin search starting just after the previous winner, wrapping
  // modulo 5; the first valid input in that order wins.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    probe = 4'd0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      probe = {1'b0, lastGrant_q} + 4'(k);
      if (probe >= 4'd5) probe = probe - 4'd5;
      if (!found && validVec[probe[2:0]]) begin
        found = 1'b1;
        pick  = probe[2:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grant_d     = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SEND;
          grant_d = pick;
        end
      end
      SEND: begin
        if (endOfPkt) begin
          state_d     = IDLE;
          lastGrant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // lastGrant resets to 4 so that input 0 is searched first.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 3'd4;
      grant_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grant_q     <= grant_d;
    end
  end

  // Counter clear wins over an increment landing on the same edge.
  always_ff @(posedge axi_aclk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (axi_reset || rst_cntrs) begin
        pktCnt_q[i] <= 32'd0;
      end else if (endOfPkt && (grant_q == 3'(i))) begin
        pktCnt_q[i] <= pktCnt_q[i] + 32'd1;
      end
    end
  end

  assign pkt_in_cntr_0 = pktCnt_q[0];
  assign pkt_in_cntr_1 = pktCnt_q[1];
  assign pkt_in_cntr_2 = pktCnt_q[2];
  assign pkt_in_cntr_3 = pktCnt_q[3];
  assign pkt_in_cntr_4 = pktCnt_q[4];
  assign grant_idx     = grant_q;

endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Testbench for nf10_rr_input_arbiter: directed scenarios followed by a long
// randomized run, all compared cycle by cycle against a packet-level model.
module tb_nf10_rr_input_arbiter;

  localparam int DW = 256;
  localparam int SW = DW / 8;
  localparam int UW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rstc;
  logic          mReady;
  logic [DW-1:0] sData [5];
  logic [SW-1:0] sStrb [5];
  logic [UW-1:0] sUser [5];
  logic [4:0]    sValid;
  logic [4:0]    sLast;

  logic [4:0]    sReadyV;
  logic [DW-1:0] mData;
  logic [SW-1:0] mStrb;
  logic [UW-1:0] mUser;
  logic          mValid;
  logic          mLast;
  logic [31:0]   cnt0, cnt1, cnt2, cnt3, cnt4;
  logic [31:0]   cntArr [5];
  logic [2:0]    grantIdx;

  assign cntArr[0] = cnt0;
  assign cntArr[1] = cnt1;
  assign cntArr[2] = cnt2;
  assign cntArr[3] = cnt3;
  assign cntArr[4] = cnt4;

  nf10_rr_input_arbiter dut (
    .axi_aclk        (clk),
    .axi_reset       (rst),
    .s_axis_tdata_0  (sData[0]), .s_axis_tstrb_0 (sStrb[0]), .s_axis_tuser_0 (sUser[0]),
    .s_axis_tvalid_0 (sValid[0]), .s_axis_tready_0 (sReadyV[0]), .s_axis_tlast_0 (sLast[0]),
    .s_axis_tdata_1  (sData[1]), .s_axis_tstrb_1 (sStrb[1]), .s_axis_tuser_1 (sUser[1]),
    .s_axis_tvalid_1 (sValid[1]), .s_axis_tready_1 (sReadyV[1]), .s_axis_tlast_1 (sLast[1]),
    .s_axis_tdata_2  (sData[2]), .s_axis_tstrb_2 (sStrb[2]), .s_axis_tuser_2 (sUser[2]),
    .s_axis_tvalid_2 (sValid[2]), .s_axis_tready_2 (sReadyV[2]), .s_axis_tlast_2 (sLast[2]),
    .s_axis_tdata_3  (sData[3]), .s_axis_tstrb_3 (sStrb[3]), .s_axis_tuser_3 (sUser[3]),
    .s_axis_tvalid_3 (sValid[3]), .s_axis_tready_3 (sReadyV[3]), .s_axis_tlast_3 (sLast[3]),
    .s_axis_tdata_4  (sData[4]), .s_axis_tstrb_4 (sStrb[4]), .s_axis_tuser_4 (sUser[4]),
    .s_axis_tvalid_4 (sValid[4]), .s_axis_tready_4 (sReadyV[4]), .s_axis_tlast_4 (sLast[4]),
    .m_axis_tdata    (mData),
    .m_axis_tstrb    (mStrb),
    .m_axis_tuser    (mUser),
    .m_axis_tvalid   (mValid),
    .m_axis_tready   (mReady),
    .m_axis_tlast    (mLast),
    .rst_cntrs       (rstc),
    .pkt_in_cntr_0   (cnt0),
    .pkt_in_cntr_1   (cnt1),
    .pkt_in_cntr_2   (cnt2),
    .pkt_in_cntr_3   (cnt3),
    .pkt_in_cntr_4   (cnt4),
    .grant_idx       (grantIdx)
  );

  // Model: which input owns the output (-1 = nobody), who won last, counters.
  int          mOwner;
  int          mLastWin;
  int          mGrant;
  logic [31:0] mCnt [5];

  // Sources: beats remaining in the current packet and a running beat id.
  int beatsLeft [5];
  int seqNo [5];
  int newPct;
  int maxLen;
  int xferLog [$];

  int vectors;
  int miscompares;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    mOwner   = -1;
    mLastWin = 4;
    mGrant   = 0;
    for (int i = 0; i < 5; i++) mCnt[i] = 32'd0;
  endtask

  task automatic setBeat(input int i);
    for (int w = 0; w < DW / 32; w++) sData[i][w*32 +: 32] = $urandom;
    sData[i][31:0]  = 32'(seqNo[i]);
    sData[i][39:32] = 8'(i);
    sStrb[i] = $urandom;
    for (int w = 0; w < UW / 32; w++) sUser[i][w*32 +: 32] = $urandom;
    sLast[i] = (beatsLeft[i] == 1);
  endtask

  task automatic loadPacket(input int i, input int n);
    beatsLeft[i] = n;
    sValid[i]    = 1'b1;
    setBeat(i);
  endtask

  task automatic clearSources();
    for (int i = 0; i < 5; i++) begin
      sValid[i]    = 1'b0;
      sLast[i]     = 1'b0;
      beatsLeft[i] = 0;
    end
  endtask

  task automatic applyStimulus();
    logic [4:0] acc;
    logic       found;
    int         idx;
    acc = '0;
    if (mOwner >= 0 && sValid[mOwner] && mReady) begin
      acc[mOwner] = 1'b1;
      xferLog.push_back(mOwner);
    end
    if (rst) begin
      resetModel();
    end else begin
      if (mOwner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= 5; k++) begin
          idx = (mLastWin + k) % 5;
          if (!found && sValid[idx]) begin
            found  = 1'b1;
            mOwner = idx;
            mGrant = idx;
          end
        end
      end else if (sValid[mOwner] && mReady && sLast[mOwner]) begin
        mCnt[mOwner] = mCnt[mOwner] + 32'd1;
        mLastWin     = mOwner;
        mOwner       = -1;
      end
      if (rstc) for (int i = 0; i < 5; i++) mCnt[i] = 32'd0;
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (acc[i]) begin
        beatsLeft[i]--;
        seqNo[i]++;
        if (beatsLeft[i] == 0) begin
          sValid[i] = 1'b0;
          sLast[i]  = 1'b0;
        end else begin
          setBeat(i);
        end
      end
      if (!sValid[i] && ($urandom_range(0, 99) < newPct))
        loadPacket(i, int'($urandom_range(1, maxLen)));
    end
  endtask

  task automatic checkOutput();
    logic       expValid;
    logic [4:0] expReady;
    expValid = 1'b0;
    expReady = '0;
    if (mOwner >= 0) begin
      expValid         = sValid[mOwner];
      expReady[mOwner] = mReady;
    end
    check("m_tvalid", DW'(mValid), DW'(expValid));
    check("s_tready", DW'(sReadyV), DW'(expReady));
    if (expValid) begin
      check("m_tdata", mData, sData[mOwner]);
      check("m_tstrb", DW'(mStrb), DW'(sStrb[mOwner]));
      check("m_tuser", DW'(mUser), DW'(sUser[mOwner]));
      check("m_tlast", DW'(mLast), DW'(sLast[mOwner]));
    end
    if (mOwner >= 0) check("grant_idx", DW'(grantIdx), DW'(mGrant));
    for (int i = 0; i < 5; i++) check($sformatf("pkt_in_cntr_%0d", i), DW'(cntArr[i]), DW'(mCnt[i]));
  endtask

  // One clock: compare just after the negedge, advance model at the posedge,
  // then update the sources at the following negedge.
  task automatic stepCycle();
    #1;
    checkOutput();
    @(posedge clk);
    applyStimulus();
  endtask

  task automatic steppedReset();
    clearSources();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    xferLog.delete();
  endtask

  initial begin
    int expC [5];
    vectors     = 0;
    miscompares = 0;
    newPct      = 0;
    maxLen      = 1;
    rstc        = 1'b0;
    mReady      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seqNo[i] = 0;
      sData[i] = '0;
      sStrb[i] = '0;
      sUser[i] = '0;
    end
    clearSources();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset tvalid", DW'(mValid), DW'(0));
    check("reset treadys", DW'(sReadyV), DW'(0));
    check("reset grant_idx", DW'(grantIdx), DW'(0));
    for (int i = 0; i < 5; i++) check($sformatf("reset cntr_%0d", i), DW'(cntArr[i]), DW'(0));

    // Single 3-beat packet on input 2.
    mReady = 1'b1;
    loadPacket(2, 3);
    xferLog.delete();
    repeat (5) stepCycle();
    check("A beats", DW'(xferLog.size()), DW'(3));
    foreach (xferLog[j]) check("A beat owner", DW'(xferLog[j]), DW'(2));
    check("A cntr_2", DW'(cnt2), DW'(1));
    check("A last_grant", DW'(mLastWin), DW'(2));

    // All five inputs continuously valid with single-beat packets.
    steppedReset();
    mReady = 1'b1;
    newPct = 100;
    maxLen = 1;
    for (int i = 0; i < 5; i++) loadPacket(i, 1);
    repeat (20) stepCycle();
    newPct = 0;
    check("B packets", DW'(xferLog.size()), DW'(10));
    foreach (xferLog[j]) check("B order", DW'(xferLog[j]), DW'(j % 5));
    for (int i = 0; i < 5; i++) check($sformatf("B cntr_%0d", i), DW'(cntArr[i]), DW'(2));

    // Input 0 requests while input 1 is mid-packet.
    steppedReset();
    mReady = 1'b1;
    loadPacket(1, 4);
    repeat (2) stepCycle();
    loadPacket(0, 1);
    repeat (8) stepCycle();
    expC = '{1, 1, 1, 1, 0};
    check("C beats", DW'(xferLog.size()), DW'(5));
    for (int j = 0; j < 5 && j < xferLog.size(); j++) check("C order", DW'(xferLog[j]), DW'(expC[j]));

    // Downstream ready toggling through a 4-beat packet on input 3.
    steppedReset();
    mReady = 1'b1;
    loadPacket(3, 4);
    stepCycle();
    for (int c = 0; c < 8; c++) begin
      mReady = (c % 2 == 0);
      stepCycle();
    end
    mReady = 1'b1;
    check("D transfers", DW'(xferLog.size()), DW'(4));
    check("D cntr_3", DW'(cnt3), DW'(1));
    repeat (2) stepCycle();

    // Counter clear coinciding with a tlast transfer.
    steppedReset();
    mReady = 1'b1;
    loadPacket(4, 1);
    repeat (3) stepCycle();
    check("E cntr_4 before", DW'(cnt4), DW'(1));
    loadPacket(4, 1);
    stepCycle();
    rstc = 1'b1;
    stepCycle();
    rstc = 1'b0;
    check("E cntr_4 cleared", DW'(cnt4), DW'(0));
    check("E transfers", DW'(xferLog.size()), DW'(2));

    // Reset on beat 2 of a 4-beat packet from input 1.
    steppedReset();
    mReady = 1'b1;
    loadPacket(1, 4);
    repeat (2) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    #1;
    check("F tvalid after reset", DW'(mValid), DW'(0));
    check("F treadys after reset", DW'(sReadyV), DW'(0));
    loadPacket(0, 1);
    xferLog.delete();
    repeat (8) stepCycle();
    check("F transfers", DW'(xferLog.size()), DW'(3));
    if (xferLog.size() > 1) begin
      check("F first winner", DW'(xferLog[0]), DW'(0));
      check("F second winner", DW'(xferLog[1]), DW'(1));
    end

    // Long randomized run.
    steppedReset();
    newPct = 30;
    maxLen = 4;
    repeat (3000) begin
      mReady = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 199) == 0);
      rstc   = ($urandom_range(0, 99) == 0);
      stepCycle();
    end
    rst  = 1'b0;
    rstc = 1'b0;
    stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
